audio_mix_sd: RTL

Parametrised successor to the ULA's fixed two-DAC audio path. Mixes NCH unsigned PCM sources (beeper/EAR/MIC, AY A/B/C, extra DACs) into stereo with per-channel, per-side programmable gains. Mixing is time-multiplexed over one multiply-accumulate per side. Output is one first-order sigma-delta bitstream per side; sits between the sound sources and the AUDIO_L/AUDIO_R pins.

---
 rtl/audio_mix_sd.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/audio_mix_sd.sv
// audio_mix_sd: mixes NCH unsigned PCM channels into stereo through
// per-channel, per-side gains. One multiply-accumulate per side is shared
// across the channels, one channel per cycle. Each side drives a
// first-order sigma-delta bitstream.
//
// Ports:
//   clk_sys, nRESET      clock and asynchronous active-low reset
//   ch_data              channel samples, channel k at [k*IW +: IW]
//   mute                 zeroes the next mix; sampled once per frame at SNAP
//   gain_we/addr/data    gain file write; data = {gain_l, gain_r}
//   mix_l, mix_r         current PCM mix, held between frames
//   frame                one-cycle pulse, aligned with the new mix values
//   AUDIO_L, AUDIO_R     sigma-delta bitstreams
module audio_mix_sd #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = 8,
  parameter int unsigned GW  = 4,
  parameter int unsigned OW  = 12,
  parameter int unsigned DIV = 64
) (
  input  logic                                 clk_sys,
  input  logic                                 nRESET,
  input  logic [NCH*IW-1:0]                    ch_data,
  input  logic                                 mute,
  input  logic                                 gain_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] gain_addr,
  input  logic [2*GW-1:0]                      gain_data,
  output logic [OW-1:0]                        mix_l,
  output logic [OW-1:0]                        mix_r,
  output logic                                 frame,
  output logic                                 AUDIO_L,
  output logic                                 AUDIO_R
);

  localparam int unsigned GAW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW  = IW + GW + $clog2(NCH);
  localparam int unsigned PW  = IW + GW;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [GAW-1:0]    idx;
  logic [AW-1:0]     acc_l, acc_r;
  logic [OW:0]       sd_l, sd_r;
  logic [GW-1:0]     gl [NCH];
  logic [GW-1:0]     gr [NCH];
  logic [GW-1:0]     sh_gl [NCH];
  logic [GW-1:0]     sh_gr [NCH];
  logic [NCH*IW-1:0] sh_data;
  logic              sh_mute;
  logic              snap_c;
  logic [IW-1:0]     sel_s;
  logic [GW-1:0]     sel_gl, sel_gr;
  logic [PW-1:0]     prod_l, prod_r;
  logic              unused_acc_lsbs;

  assign snap_c = (cnt == '0);
  // Truncated accumulator LSBs are intentionally dropped.
  assign unused_acc_lsbs = ^{acc_l, acc_r};

  // State register
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state: SNAP on cnt==0 always restarts a frame
  always_comb begin
    state_nx = state;
    if (snap_c) begin
      state_nx = S_ACC;
    end else begin
      case (state)
        S_ACC:   if (idx == GAW'(NCH - 1)) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // Channel select from the snapshot for the current idx
  always_comb begin
    sel_s  = '0;
    sel_gl = '0;
    sel_gr = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (idx == GAW'(k)) begin
        sel_s  = sh_data[k*IW +: IW];
        sel_gl = sh_gl[k];
        sel_gr = sh_gr[k];
      end
    end
    prod_l = PW'(sel_s) * PW'(sel_gl);
    prod_r = PW'(sel_s) * PW'(sel_gr);
  end

  // Gain file; a write on the SNAP edge lands after the snapshot took the old value
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      for (int k = 0; k < int'(NCH); k++) begin
        gl[k] <= '1;
        gr[k] <= '1;
      end
    end else if (gain_we) begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (gain_addr == GAW'(k)) begin
          gl[k] <= gain_data[2*GW-1:GW];
          gr[k] <= gain_data[GW-1:0];
        end
      end
    end
  end

  // Frame snapshot of samples, gains and mute
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      sh_data <= '0;
      sh_mute <= 1'b0;
      for (int k = 0; k < int'(NCH); k++) begin
        sh_gl[k] <= '1;
        sh_gr[k] <= '1;
      end
    end else if (snap_c) begin
      sh_data <= ch_data;
      sh_mute <= mute;
      for (int k = 0; k < int'(NCH); k++) begin
        sh_gl[k] <= gl[k];
        sh_gr[k] <= gr[k];
      end
    end
  end

  // Frame counter, MAC, mix output and frame pulse
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      cnt   <= '0;
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      mix_l <= '0;
      mix_r <= '0;
      frame <= 1'b0;
    end else begin
      cnt   <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      frame <= (state == S_DONE);
      if (snap_c) begin
        idx   <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end else if (state == S_ACC) begin
        idx   <= idx + GAW'(1);
        acc_l <= acc_l + AW'(prod_l);
        acc_r <= acc_r + AW'(prod_r);
      end
      if (state == S_DONE) begin
        mix_l <= sh_mute ? '0 : acc_l[AW-1 -: OW];
        mix_r <= sh_mute ? '0 : acc_r[AW-1 -: OW];
      end
    end
  end

  // First-order sigma-delta: carry out of an OW-bit phase accumulator
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      sd_l    <= '0;
      sd_r    <= '0;
      AUDIO_L <= 1'b0;
      AUDIO_R <= 1'b0;
    end else begin
      sd_l    <= {1'b0, sd_l[OW-1:0]} + {1'b0, mix_l};
      sd_r    <= {1'b0, sd_r[OW-1:0]} + {1'b0, mix_r};
      AUDIO_L <= sd_l[OW];
      AUDIO_R <= sd_r[OW];
    end
  end

endmodule
